// File: rtl/seg_scan_mux.sv
// Multiplexed scanner for a common-anode 7-segment display. Latches a packed
// hex value, lights one digit per slot with an all-off guard gap between
// digits, and feeds a 5-bit code to the downstream hex-to-segment decoder.
module seg_scan_mux #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [4:0]            digit_code,
  output logic [DIGITS-1:0]     an_n,
  output logic                  dp_n,
  output logic                  frame_tick
);

  localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(DIGITS);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {S_SHOW, S_GUARD} state_t;

  logic [DIGITS-1:0][3:0] value_q;
  logic [DIGITS-1:0]      dp_q;
  state_t                 state;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;

  logic [IW-1:0]          idx_nxt;
  logic                   wrap;
  logic [DIGITS-1:0]      nib_zero;
  logic [DIGITS-1:0]      zsuf;      // zsuf[i]: nibbles i..DIGITS-1 all zero
  logic                   acc;

  assign wrap    = (idx == IDX_LAST);
  assign idx_nxt = wrap ? '0 : idx + 1'b1;

  // Per-digit zero detect on the latched value.
  for (genvar i = 0; i < DIGITS; i++) begin : g_nz
    assign nib_zero[i] = (value_q[i] == 4'h0);
  end

  // Suffix-AND from the most significant digit down, used for leading-zero blanking.
  always_comb begin
    zsuf = '0;
    acc  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc     = acc & nib_zero[i];
      zsuf[i] = acc;
    end
  end

  // Value/decimal-point latch; load never disturbs the scan timing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      value_q <= '0;
      dp_q    <= '0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp_in;
    end
  end

  // Scan FSM: SHOW for DIV clocks, then GUARD for GUARD clocks, then next digit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_SHOW;
      idx        <= '0;
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        S_SHOW: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (GUARD > 0) begin
              state <= S_GUARD;
            end else begin
              idx        <= idx_nxt;
              frame_tick <= wrap;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            cnt        <= '0;
            state      <= S_SHOW;
            idx        <= idx_nxt;
            frame_tick <= wrap;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_SHOW;
      endcase
    end
  end

  // Output decode from registers only; blank_lz is the sole live input.
  always_comb begin
    digit_code = 5'h10;
    an_n       = '1;
    dp_n       = 1'b1;
    if (state == S_SHOW) begin
      for (int i = 0; i < DIGITS; i++)
        if (idx == IW'(i)) an_n[i] = 1'b0;
      dp_n = ~dp_q[idx];
      if (!(blank_lz && (idx != '0) && zsuf[idx]))
        digit_code = {1'b0, value_q[idx]};
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with DIGITS=4, DIV=4, GUARD=1 (20-clock frame).
module tb_seg_scan_mux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [4:0]  digit_code;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame_tick;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;   // clocks since last reset edge

  seg_scan_mux #(.DIGITS(4), .DIV(4), .GUARD(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_code (digit_code),
    .an_n       (an_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to slot s (0..3), position p (0..3 lit, 4 guard); at most 19 clocks.
  task automatic goto(input int s, input int p);
    for (int k = 0; k < 20; k++) begin
      if ((cyc % 20) == s * 5 + p) return;
      tick();
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input int s, input logic [4:0] code, input logic dpn);
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    goto(s, 1);
    chk({tag, "_an"}, an_n, an_tab[s]);
    chk({tag, "_code"}, digit_code, code);
    chk({tag, "_dp"}, dp_n, dpn);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    reset_n = 1'b0; value = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    cyc = 0;

    // 1: reset state then 40 clocks of scan with value 0
    chk("rst_an",   an_n,       4'b1110);
    chk("rst_code", digit_code, 5'h00);
    chk("rst_dp",   dp_n,       1'b1);
    chk("rst_ft",   frame_tick, 1'b0);
    for (int c = 0; c < 40; c++) begin
      int p, s;
      p = c % 5;
      s = (c / 5) % 4;
      chk("s1_an",   an_n,       (p < 4) ? an_tab[s] : 4'b1111);
      chk("s1_code", digit_code, (p < 4) ? 5'h00 : 5'h10);
      chk("s1_dp",   dp_n,       1'b1);
      chk("s1_ft",   frame_tick, (c == 20) ? 1'b1 : 1'b0);
      tick();
    end

    // 2: value A3F7, dp on digit 2 only
    do_load(16'hA3F7, 4'b0100);
    chk_slot("s2_d0", 0, 5'h07, 1'b1);
    chk_slot("s2_d1", 1, 5'h0F, 1'b1);
    chk_slot("s2_d2", 2, 5'h03, 1'b0);
    goto(2, 4);
    chk("s2_guard_an", an_n,       4'b1111);
    chk("s2_guard_dp", dp_n,       1'b1);
    chk("s2_guard_cd", digit_code, 5'h10);
    chk_slot("s2_d3", 3, 5'h0A, 1'b1);

    // 3: leading-zero blanking on 0042, then live disable
    blank_lz = 1'b1;
    do_load(16'h0042, 4'b0000);
    chk_slot("s3_d0", 0, 5'h02, 1'b1);
    chk_slot("s3_d1", 1, 5'h04, 1'b1);
    chk_slot("s3_d2", 2, 5'h10, 1'b1);
    chk_slot("s3_d3", 3, 5'h10, 1'b1);
    blank_lz = 1'b0;
    #1;
    chk("s3_live", digit_code, 5'h00);
    chk_slot("s3_d2_nb", 2, 5'h00, 1'b1);

    // 4: all zero with blanking; digit 0 stays, dp survives a blanked digit
    blank_lz = 1'b1;
    do_load(16'h0000, 4'b1000);
    chk_slot("s4_d0", 0, 5'h00, 1'b1);
    chk_slot("s4_d1", 1, 5'h10, 1'b1);
    chk_slot("s4_d2", 2, 5'h10, 1'b1);
    chk_slot("s4_d3", 3, 5'h10, 1'b0);

    // 5: mid-slot load of 1234 in digit 1's second lit cycle
    blank_lz = 1'b0;
    goto(1, 1);
    chk("s5_pre", digit_code, 5'h00);
    value = 16'h1234; dp_in = 4'b0000; load = 1'b1;
    tick();
    load = 1'b0;
    chk("s5_p2_code", digit_code, 5'h03);
    chk("s5_p2_an",   an_n,       4'b1101);
    tick();
    chk("s5_p3_an",   an_n,       4'b1101);
    tick();
    chk("s5_p4_an",   an_n,       4'b1111);
    tick();
    chk("s5_d2_an",   an_n,       4'b1011);
    chk("s5_d2_code", digit_code, 5'h02);
    goto(0, 0);
    chk("s5_ft",      frame_tick, 1'b1);
    chk("s5_d0_code", digit_code, 5'h04);

    // 6: reset during the guard after slot 2; load ignored while in reset
    goto(2, 4);
    reset_n = 1'b0; value = 16'hFFFF; load = 1'b1;
    tick();
    reset_n = 1'b1; load = 1'b0;
    cyc = 0;
    chk("s6_an",   an_n,       4'b1110);
    chk("s6_code", digit_code, 5'h00);
    chk("s6_dp",   dp_n,       1'b1);
    chk("s6_ft",   frame_tick, 1'b0);
    begin
      int ft_cnt;
      ft_cnt = 0;
      for (int c = 0; c < 20; c++) begin
        if (frame_tick) ft_cnt++;
        tick();
      end
      chk("s6_no_ft", ft_cnt, 0);
      chk("s6_wrap_ft", frame_tick, 1'b1);
      chk("s6_wrap_an", an_n, 4'b1110);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
